// File: rtl/me_pkg.sv
// Shared constants, FSM encoding and SAD saturation for the motion-estimation result path.
package me_pkg;

    localparam int FRAME_W   = 20;
    localparam int MV_W      = 5;
    localparam int SAD_IN_W  = 16;
    localparam int SAD_OUT_W = 10;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Clamp the comparator SAD to the largest value the frame field can carry.
    function automatic logic [SAD_OUT_W-1:0] sat_sad(input logic [SAD_IN_W-1:0] sad);
        if (sad > SAD_IN_W'((1 << SAD_OUT_W) - 1)) begin
            return '1;
        end
        return sad[SAD_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/me_result_serializer.sv
// Frames each best-match result (mv_y, mv_x, saturated SAD) as start bit + 20 data bits, MSB first,
// on serial20; a one-entry buffer accepts the next result while the current one shifts.
module me_result_serializer
    import me_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [MV_W-1:0]     res_mv_x,
    input  logic [MV_W-1:0]     res_mv_y,
    input  logic [SAD_IN_W-1:0] res_sad,
    output logic                serial20,
    output logic                busy
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_next;
    logic               buf_full;
    logic [FRAME_W-1:0] buf_word;
    logic [FRAME_W-1:0] shreg;
    logic               load;
    logic               serial_next;
    logic               accept;

    // Ready depends only on registered occupancy and init, never on res_valid.
    assign res_ready = ~buf_full & ~init;
    assign accept    = res_valid & res_ready;
    assign busy      = (state != ST_IDLE) | buf_full;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        load         = 1'b0;
        serial_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    load       = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                serial_next  = 1'b1;
                bit_cnt_next = CNT_W'(FRAME_W - 1);
                state_next   = ST_SHIFT;
            end
            ST_SHIFT: begin
                serial_next = shreg[bit_cnt];
                if (bit_cnt == '0) begin
                    // A waiting word starts immediately, so frames stay contiguous.
                    if (buf_full) begin
                        load       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            serial20 <= 1'b0;
            buf_full <= 1'b0;
        end else if (init) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            serial20 <= 1'b0;
            buf_full <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            serial20 <= serial_next;
            // accept needs an empty buffer and load a full one, so they never coincide.
            buf_full <= accept | (buf_full & ~load);
        end
    end

    // NOTE: data-only registers carry no reset; buf_full and the FSM qualify their contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_word <= {res_mv_y, res_mv_x, sat_sad(res_sad)};
        end
        if (load) begin
            shreg <= buf_word;
        end
    end

endmodule
